// File: rtl/iic_slave_eeprom.sv
`default_nettype none
// ============================================================================
//  Module   : iic_slave_eeprom
//  Brief    : I2C target modelling a 24Cxx-style EEPROM. Oversamples SCL/SDA,
//             detects START/STOP, decodes device and word address, then
//             accepts write bytes or returns read bytes from internal memory.
//  Revision : 1.0  initial release
// ============================================================================
module iic_slave_eeprom #(
    parameter logic [6:0] DEV_ADDR = 7'b1010000,
    parameter logic       BIT_CTRL = 1'b1,
    parameter int         MEM_AW   = 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              scl,
    inout  wire               sda,
    output logic              busy,
    output logic              wr_stb,
    output logic [MEM_AW-1:0] wr_addr,
    output logic [7:0]        wr_byte,
    output logic [7:0]        nack_cnt
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_DEV_ADDR  = 4'd1,
        S_ADDR_H    = 4'd2,
        S_ADDR_L    = 4'd3,
        S_WR_DATA   = 4'd4,
        S_ACK       = 4'd5,
        S_RD_DATA   = 4'd6,
        S_RD_ACK    = 4'd7,
        S_IDLE_WAIT = 4'd8
    } state_t;

    // Synchroniser and history flops; reset to the idle-bus level (both high)
    logic scl_s1_q, scl_s2_q, scl_h_q;
    logic sda_s1_q, sda_s2_q, sda_h_q;
    logic fall_d1_q;

    state_t              state_q, state_d;
    state_t              ret_q, ret_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [7:0]          shift_q, shift_d;
    logic [7:0]          hi_q, hi_d;
    logic [MEM_AW-1:0]   ptr_q, ptr_d;
    logic                sda_oe_q, sda_oe_d;
    logic                busy_q, busy_d;
    logic                wr_stb_q, wr_stb_d;
    logic [MEM_AW-1:0]   wr_addr_q, wr_addr_d;
    logic [7:0]          wr_byte_q, wr_byte_d;
    logic [7:0]          nack_q, nack_d;
    logic                mem_we;

    logic [7:0]          mem_q [2**MEM_AW];

    logic                w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0]          w_rx_byte;
    logic [7:0]          w_rd_byte;
    logic [15:0]         w_addr16;

    assign w_scl_rise = scl_s2_q & ~scl_h_q;
    assign w_scl_fall = ~scl_s2_q & scl_h_q;
    assign w_start    = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
    assign w_stop     = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;
    assign w_rx_byte  = {shift_q[6:0], sda_s2_q};
    assign w_rd_byte  = mem_q[ptr_q];
    assign w_addr16   = {(BIT_CTRL ? hi_q : 8'h00), w_rx_byte};

    // Open-drain driver; reset gates it off combinationally so the line is
    // released in the very cycle reset is applied
    assign sda = (sda_oe_q && !sys_rst) ? 1'b0 : 1'bz;

    assign busy     = busy_q;
    assign wr_stb   = wr_stb_q;
    assign wr_addr  = wr_addr_q;
    assign wr_byte  = wr_byte_q;
    assign nack_cnt = nack_q;

    // Pin synchronisers, history flops and delayed falling-edge strobe
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            scl_s1_q  <= 1'b1;
            scl_s2_q  <= 1'b1;
            scl_h_q   <= 1'b1;
            sda_s1_q  <= 1'b1;
            sda_s2_q  <= 1'b1;
            sda_h_q   <= 1'b1;
            fall_d1_q <= 1'b0;
        end else begin
            scl_s1_q  <= scl;
            scl_s2_q  <= scl_s1_q;
            scl_h_q   <= scl_s2_q;
            sda_s1_q  <= sda;
            sda_s2_q  <= sda_s1_q;
            sda_h_q   <= sda_s2_q;
            fall_d1_q <= w_scl_fall;
        end
    end

    // Protocol state and output registers
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= S_IDLE;
            ret_q     <= S_IDLE;
            cnt_q     <= 4'd0;
            shift_q   <= 8'h00;
            hi_q      <= 8'h00;
            ptr_q     <= '0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_byte_q <= 8'h00;
            nack_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            hi_q      <= hi_d;
            ptr_q     <= ptr_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            wr_stb_q  <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
            wr_byte_q <= wr_byte_d;
            nack_q    <= nack_d;
        end
    end

    // Byte storage; contents survive reset
    always_ff @(posedge sys_clk) begin
        if (mem_we && !sys_rst) begin
            mem_q[ptr_q] <= w_rx_byte;
        end
    end

    // Next-state logic: START/STOP override everything, otherwise walk the
    // byte/ACK sequence on synchronised SCL edges
    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        hi_d      = hi_q;
        ptr_d     = ptr_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_byte_d = wr_byte_q;
        nack_d    = nack_q;
        mem_we    = 1'b0;

        if (w_start) begin
            state_d  = S_DEV_ADDR;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b1;
        end else if (w_stop) begin
            state_d  = S_IDLE;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                S_DEV_ADDR, S_ADDR_H, S_ADDR_L, S_WR_DATA: begin
                    if (w_scl_rise) begin
                        shift_d = w_rx_byte;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            cnt_d   = 4'd0;
                            state_d = S_ACK;
                            case (state_q)
                                S_DEV_ADDR: begin
                                    if (w_rx_byte[7:1] == DEV_ADDR) begin
                                        if (w_rx_byte[0]) begin
                                            ret_d = S_RD_DATA;
                                        end else begin
                                            ret_d = BIT_CTRL ? S_ADDR_H : S_ADDR_L;
                                        end
                                    end else begin
                                        state_d = S_IDLE_WAIT;
                                        if (nack_q != 8'hFF) begin
                                            nack_d = nack_q + 8'd1;
                                        end
                                    end
                                end
                                S_ADDR_H: begin
                                    hi_d  = w_rx_byte;
                                    ret_d = S_ADDR_L;
                                end
                                S_ADDR_L: begin
                                    ptr_d = w_addr16[MEM_AW-1:0];
                                    ret_d = S_WR_DATA;
                                end
                                default: begin
                                    mem_we    = 1'b1;
                                    wr_stb_d  = 1'b1;
                                    wr_addr_d = ptr_q;
                                    wr_byte_d = w_rx_byte;
                                    ptr_d     = ptr_q + MEM_AW'(1);
                                    ret_d     = S_WR_DATA;
                                end
                            endcase
                        end
                    end
                end
                S_ACK: begin
                    // First fall (end of bit 8) asserts ACK, second fall
                    // (end of bit 9) hands the line to the next phase
                    if (fall_d1_q) begin
                        if (cnt_q == 4'd0) begin
                            sda_oe_d = 1'b1;
                            cnt_d    = 4'd1;
                        end else begin
                            cnt_d   = 4'd0;
                            state_d = ret_q;
                            if (ret_q == S_RD_DATA) begin
                                shift_d  = w_rd_byte;
                                sda_oe_d = ~w_rd_byte[7];
                            end else begin
                                sda_oe_d = 1'b0;
                            end
                        end
                    end
                end
                S_RD_DATA: begin
                    if (w_scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (fall_d1_q) begin
                        if (cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            cnt_d    = 4'd0;
                            state_d  = S_RD_ACK;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                        end
                    end
                end
                S_RD_ACK: begin
                    if (w_scl_rise) begin
                        if (!sda_s2_q) begin
                            ptr_d = ptr_q + MEM_AW'(1);
                            cnt_d = 4'd1;
                        end else begin
                            state_d = S_IDLE_WAIT;
                        end
                    end else if (fall_d1_q && (cnt_q == 4'd1)) begin
                        cnt_d    = 4'd0;
                        state_d  = S_RD_DATA;
                        shift_d  = w_rd_byte;
                        sda_oe_d = ~w_rd_byte[7];
                    end
                end
                default: begin
                    // IDLE and IDLE_WAIT: bus ignored until START/STOP
                end
            endcase
        end
    end

endmodule
`default_nettype wire
